// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add multiplier sequencer for MUL, UMULL and SMULL.
// SMULL multiplies operand magnitudes and negates the 64-bit sum in FIX.
module mul_sequencer #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi,
   output logic        neg,
   output logic        zero
);
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [63:0]   r_acc, w_fixed;
   logic [31:0]   r_mcand, r_mplier;
   logic          r_long, r_neg_fix, w_accept, w_last, w_smull;
   assign w_smull = op == 2'b11;
   assign w_last  = r_cnt == CW'(ITER - 1);
   assign w_fixed = r_neg_fix ? -r_acc : r_acc;
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = (r_state == CALC) || (r_state == FIX);
      done     = r_state == DONE;
      case (r_state)
         IDLE, DONE: begin
            w_accept = start;
            w_next   = start ? CALC : IDLE;
         end
         CALC:    w_next = w_last ? FIX : CALC;
         default: w_next = DONE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_neg_fix <= 1'b0;
         r_long    <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         result_lo <= '0;
         result_hi <= '0;
         neg       <= 1'b0;
         zero      <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_long    <= op[1];
            r_mcand   <= (w_smull && a[31]) ? -a : a;
            r_mplier  <= (w_smull && b[31]) ? -b : b;
            r_neg_fix <= w_smull && (a[31] ^ b[31]);
            r_acc     <= '0;
            r_cnt     <= '0;
         end else if (r_state == CALC) begin
            if (r_mplier[0]) r_acc <= r_acc + (64'(r_mcand) << r_cnt);
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end else if (r_state == FIX) begin
            // outputs load on the edge that enters DONE
            r_acc     <= w_fixed;
            result_lo <= w_fixed[31:0];
            result_hi <= r_long ? w_fixed[63:32] : 32'd0;
            neg       <= r_long ? w_fixed[63] : w_fixed[31];
            zero      <= r_long ? (w_fixed == 64'd0) : (w_fixed[31:0] == 32'd0);
         end
      end
   end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed vectors with hand-computed products and latency checks.
module tb_mul_sequencer;
   localparam int ITER = 32;
   logic        clk, reset, start, busy, done, neg, zero;
   logic [1:0]  op;
   logic [31:0] a, b, result_lo, result_hi;
   int          checks = 0;
   int          errors = 0;

   mul_sequencer #(.ITER(ITER)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .neg(neg), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int hold, input logic [63:0] exp, input logic en, input logic ez);
      int n, extra;
      logic seen;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < ITER + 10) begin
         @(negedge clk);
         n++;
         if (n >= hold) start = 1'b0;
         a = ~a; b = b + 32'd1; op = ~op;
         if (n == 1) chk({tag, "_busy_calc"}, 64'(busy), 64'd1);
         if (n == ITER + 1) chk({tag, "_busy_fix"}, 64'(busy), 64'd1);
         seen = done;
      end
      chk({tag, "_latency"}, 64'(n), 64'(ITER + 2));
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      chk({tag, "_lo"}, 64'(result_lo), 64'(exp[31:0]));
      chk({tag, "_hi"}, 64'(result_hi), 64'(exp[63:32]));
      chk({tag, "_neg"}, 64'(neg), 64'(en));
      chk({tag, "_zero"}, 64'(zero), 64'(ez));
      extra = 0;
      repeat (ITER + 4) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk({tag, "_extra_done"}, 64'(extra), 64'd0);
      chk({tag, "_hold_lo"}, 64'(result_lo), 64'(exp[31:0]));
   endtask

   initial begin
      int n, extra;
      logic seen;
      reset = 1'b0; start = 1'b1; op = 2'b10; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_lo", 64'(result_lo), 64'd0);
      chk("rst_hi", 64'(result_hi), 64'd0);
      chk("rst_neg", 64'(neg), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      reset = 1'b1; start = 1'b0;

      run("umull_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
      run("smull_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      run("smull_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
      run("smull_5xm3", 2'b11, 32'd5, 32'hFFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0);
      run("mul_hold", 2'b00, 32'd7, 32'd6, 5, 64'h0000_0000_0000_002A, 1'b0, 1'b0);
      run("mul_neg", 2'b01, 32'hFFFF_FFFF, 32'd2, 1, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0);
      run("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 1, 64'd0, 1'b0, 1'b1);
      run("umull_big", 2'b10, 32'h0001_0000, 32'h0001_0000, 1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);

      // abort in the middle of CALC
      @(negedge clk);
      op = 2'b10; a = 32'd3; b = 32'd5; start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_lo", 64'(result_lo), 64'd0);
      chk("abort_hi", 64'(result_hi), 64'd0);
      chk("abort_zero", 64'(zero), 64'd1);
      reset = 1'b1;
      extra = 0;
      repeat (ITER + 4) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      chk("abort_quiet", 64'(extra), 64'd0);

      // back-to-back: second start lands in the DONE cycle of the first
      @(negedge clk);
      op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < ITER + 10) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         seen = done;
      end
      chk("b2b_lat1", 64'(n), 64'(ITER + 2));
      chk("b2b_lo1", 64'(result_lo), 64'h2A);
      op = 2'b00; a = 32'd0; b = 32'd9; start = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < ITER + 10) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (n == 1) chk("b2b_busy", 64'(busy), 64'd1);
         seen = done;
      end
      chk("b2b_spacing", 64'(n), 64'(ITER + 2));
      chk("b2b_lo2", 64'(result_lo), 64'd0);
      chk("b2b_hi2", 64'(result_hi), 64'd0);
      chk("b2b_zero2", 64'(zero), 64'd1);
      @(negedge clk);
      chk("b2b_pulse", 64'(done), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have a parameter ITER, default 32, giving the number of shift-add iterations per operation.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- start  in  1  request to begin an operation; accepted only in IDLE or DONE.
- op  in  2  operation code: 00 or 01 = MUL; 10 = UMULL; 11 = SMULL.
- a  in  32  multiplicand (Rn value); sampled only on the accept edge.
- b  in  32  multiplier (Rm value); sampled only on the accept edge.
- busy  out  1  high while an operation is in progress; used by the main FSM as stall.
- done  out  1  one-cycle pulse marking result_lo/result_hi valid.
- result_lo  out  32  product bits [31:0].
- result_hi  out  32  product bits [63:32]; forced to 0 for MUL.
- neg  out  1  result sign: bit 63 for long ops, bit 31 for MUL.
- zero  out  1  result is zero: full 64 bits for long ops, result_lo for MUL.

Function
REQ-003 The controller SHALL be an FSM with four states: IDLE, CALC, FIX, DONE.
REQ-004 In IDLE or DONE, start=1 SHALL cause the block on that edge to:
- latch op, a and b;
- clear the 64-bit accumulator and the iteration counter;
- go to CALC.
REQ-005 For SMULL, on the accept edge the block SHALL:
- latch |a| and |b| as operands;
- store neg_fix = a[31] XOR b[31].
For MUL and UMULL, neg_fix SHALL be 0.
REQ-006 Each CALC cycle SHALL perform one iteration:
- if the multiplier LSB is 1, add the multiplicand (zero-extended to 64 bits, shifted left by the counter) into the accumulator;
- shift the multiplier right by 1;
- increment the counter.
REQ-007 CALC SHALL last exactly ITER cycles; when the counter reaches ITER-1, the next state SHALL be FIX.
REQ-008 FIX SHALL last one cycle: the accumulator takes its two's complement if neg_fix=1 and is otherwise unchanged; the next state is DONE.
REQ-009 In DONE, done SHALL be 1 for exactly one cycle, and result_lo, result_hi, neg and zero SHALL be updated on the edge entering DONE.
REQ-010 After DONE, the block SHALL return to IDLE, unless start=1 in the DONE cycle, in which case it SHALL go to CALC (back-to-back operation).
REQ-011 busy SHALL be 1 exactly in CALC and FIX.
REQ-012 Latency SHALL be fixed: with start accepted at edge k, done=1 in the cycle after edge k+ITER+1, i.e. ITER+2 cycles after the accept edge, independent of operand values.
REQ-013 start asserted in CALC or FIX SHALL be ignored, with no effect on operands, state or counter.
REQ-014 result outputs SHALL hold their values from DONE until the next DONE or reset; a, b and op changes outside the accept edge SHALL have no effect.
REQ-015 For MUL, result_hi SHALL be 0 and result_lo SHALL be the low 32 bits of the unsigned product (identical to the signed low word).
REQ-016 The accumulator SHALL be 64 bits wide, with no overflow possible; the SMULL magnitude of 0x80000000 SHALL be treated as unsigned 2^31.

Reset
REQ-017 While reset=0 at a rising edge, the block SHALL:
- enter IDLE;
- clear the counter, accumulator and neg_fix;
- drive busy=0, done=0, result_lo=0, result_hi=0, neg=0, zero=1.
REQ-018 Reset asserted in CALC or FIX SHALL abort the operation with no done pulse and no result update.
REQ-019 Reset SHALL take priority over start on the same edge.

Verification
REQ-020 UMULL, a=0xFFFFFFFF, b=0xFFFFFFFF -> after ITER+2 cycles: done=1 for one cycle, result_hi=0xFFFFFFFE, result_lo=0x00000001, neg=1, zero=0.
REQ-021 SMULL, a=0xFFFFFFFF (-1), b=0x00000002 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE, neg=1.
REQ-022 SMULL, a=0x80000000, b=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000, neg=0, zero=0.
REQ-023 MUL, a=7, b=6, with start held high for 5 cycles -> exactly one operation runs; result_lo=0x0000002A, result_hi=0, a single done pulse.
REQ-024 UMULL, a=3, b=5, with reset=0 applied on CALC cycle 10 -> next cycle: IDLE, busy=0, outputs 0, zero=1, no done pulse. A following MUL, a=0, b=9, with start in the DONE cycle of a prior op -> back-to-back: zero=1, done pulses spaced ITER+2 cycles apart.
